// File: rtl/adau1761_axil_slave_regs_if.sv
// ---------------------------------------------------------------------------
// adau1761_axil_slave_regs_if
// AXI4-Lite bus bundle between a lite master and the ADAU1761 control-register
// slave. Carries the five AXI4-Lite channels (AW, W, B, AR, R).
//   master modport : drives addresses, write data, VALIDs and response READYs
//   slave  modport : drives AWREADY/WREADY/ARREADY, B and R channel outputs
// Clock and reset are not part of the bundle; they stay plain module ports.
// ---------------------------------------------------------------------------
interface adau1761_axil_slave_regs_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/adau1761_axil_slave_regs.sv
// ---------------------------------------------------------------------------
// adau1761_axil_slave_regs
// AXI4-Lite slave holding four 32-bit read/write control registers for the
// ADAU1761 codec controller. One outstanding write and one outstanding read;
// the two directions run independently. Responses are always OKAY.
// Ports:
//   S_AXI_ACLK     clock, all logic on the rising edge
//   S_AXI_ARESETN  synchronous reset, active low
//   s_axi          AXI4-Lite slave bundle (AW, W, B, AR, R channels)
//   reg_out        {reg3, reg2, reg1, reg0}
//   wr_pulse       one-cycle strobe when a write commits
//   wr_index       register index of the commit, valid while wr_pulse is high
// ---------------------------------------------------------------------------
module adau1761_axil_slave_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  adau1761_axil_slave_regs_if.slave         s_axi,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0]   reg_out,
  output logic                              wr_pulse,
  output logic [1:0]                        wr_index
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;

  // Byte-lane merge: lanes with a set strobe take the new data, others keep old.
  function automatic logic [DW-1:0] byte_merge(
    input logic [DW-1:0] old_v,
    input logic [DW-1:0] new_v,
    input logic [SW-1:0] strb
  );
    logic [DW-1:0] res;
    res = old_v;
    for (int i = 0; i < SW; i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = new_v[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_v[8*i +: 8];
      end
    end
    return res;
  endfunction

  logic                 rst_done_r;
  logic                 aw_held_r;
  logic [1:0]           aw_idx_r;
  logic                 w_held_r;
  logic [DW-1:0]        w_data_r;
  logic [SW-1:0]        w_strb_r;
  logic                 bvalid_r;
  logic                 rvalid_r;
  logic [DW-1:0]        rdata_r;
  logic                 wr_pulse_r;
  logic [1:0]           wr_index_r;
  logic [3:0][DW-1:0]   regs_r;

  logic                 awready_s;
  logic                 wready_s;
  logic                 arready_s;
  logic                 aw_hs_s;
  logic                 w_hs_s;
  logic                 ar_hs_s;
  logic                 commit_s;
  logic                 unused_s;

  // PROT fields and the byte-offset address bits carry no meaning here.
  assign unused_s = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

  // Channel readiness: nothing is accepted until reset has completed, and a
  // pending response blocks new requests in its direction.
  always_comb begin
    awready_s = 1'b0;
    wready_s  = 1'b0;
    arready_s = 1'b0;
    if (rst_done_r) begin
      awready_s = ~aw_held_r & ~bvalid_r;
      wready_s  = ~w_held_r & ~bvalid_r;
      arready_s = ~rvalid_r;
    end else begin
      awready_s = 1'b0;
      wready_s  = 1'b0;
      arready_s = 1'b0;
    end
  end

  // Handshake and commit qualifiers.
  always_comb begin
    aw_hs_s  = s_axi.awvalid & awready_s;
    w_hs_s   = s_axi.wvalid & wready_s;
    ar_hs_s  = s_axi.arvalid & arready_s;
    // Commit only once both halves are already held, so a same-cycle AW+W
    // handshake commits on the following edge.
    commit_s = aw_held_r & w_held_r;
  end

  // Reset-completion flag; keeps READYs low on the first edge after release.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      rst_done_r <= 1'b0;
    end else begin
      rst_done_r <= 1'b1;
    end
  end

  // Write channel: capture AW and W independently, commit, then hold B.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      aw_held_r  <= 1'b0;
      aw_idx_r   <= 2'b00;
      w_held_r   <= 1'b0;
      w_data_r   <= {DW{1'b0}};
      w_strb_r   <= {SW{1'b0}};
      bvalid_r   <= 1'b0;
      wr_pulse_r <= 1'b0;
      wr_index_r <= 2'b00;
    end else begin
      wr_pulse_r <= 1'b0;
      if (commit_s) begin
        aw_held_r  <= 1'b0;
        w_held_r   <= 1'b0;
        bvalid_r   <= 1'b1;
        wr_pulse_r <= 1'b1;
        wr_index_r <= aw_idx_r;
      end else begin
        if (aw_hs_s) begin
          aw_held_r <= 1'b1;
          aw_idx_r  <= s_axi.awaddr[3:2];
        end
        if (w_hs_s) begin
          w_held_r <= 1'b1;
          w_data_r <= s_axi.wdata;
          w_strb_r <= s_axi.wstrb;
        end
        if (bvalid_r && s_axi.bready) begin
          bvalid_r <= 1'b0;
        end
      end
    end
  end

  // Register file: byte-masked update of the addressed register on commit.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      regs_r <= {(4*DW){1'b0}};
    end else if (commit_s) begin
      regs_r[aw_idx_r] <= byte_merge(regs_r[aw_idx_r], w_data_r, w_strb_r);
    end
  end

  // Read channel: load RDATA on the AR handshake and hold it until RREADY.
  // A read on the commit edge sees the pre-write value since regs_r updates
  // on the same edge.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      rvalid_r <= 1'b0;
      rdata_r  <= {DW{1'b0}};
    end else begin
      if (ar_hs_s) begin
        rvalid_r <= 1'b1;
        rdata_r  <= regs_r[s_axi.araddr[3:2]];
      end else if (rvalid_r && s_axi.rready) begin
        rvalid_r <= 1'b0;
      end
    end
  end

  assign s_axi.awready = awready_s;
  assign s_axi.wready  = wready_s;
  assign s_axi.arready = arready_s;
  assign s_axi.bvalid  = bvalid_r;
  assign s_axi.bresp   = 2'b00;
  assign s_axi.rvalid  = rvalid_r;
  assign s_axi.rdata   = rdata_r;
  assign s_axi.rresp   = 2'b00;
  assign reg_out       = regs_r;
  assign wr_pulse      = wr_pulse_r;
  assign wr_index      = wr_index_r;

endmodule

// File: tb/tb_adau1761_axil_slave_regs.sv
// ---------------------------------------------------------------------------
// tb_adau1761_axil_slave_regs
// Self-checking bench for adau1761_axil_slave_regs: directed scenarios plus
// randomized AXI4-Lite traffic, checked every cycle against a queue-based
// reference model, with a few literal expectations on read-back values.
// ---------------------------------------------------------------------------
module tb_adau1761_axil_slave_regs;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  adau1761_axil_slave_regs_if #(.ADDR_W(4), .DATA_W(32)) bus();

  logic [127:0] reg_out;
  logic         wr_pulse;
  logic [1:0]   wr_index;

  adau1761_axil_slave_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rstn),
    .s_axi        (bus.slave),
    .reg_out      (reg_out),
    .wr_pulse     (wr_pulse),
    .wr_index     (wr_index)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  int pulse_cnt = 0;
  logic [1:0] last_idx = 2'b00;

  // ---------------- reference model ----------------
  logic [31:0] m_regs [4];
  logic [1:0]  aw_q [$];
  logic [35:0] w_q  [$];   // {strb, data}
  bit          m_rst_done = 1'b0;
  bit          m_bvalid = 1'b0;
  bit          m_rvalid = 1'b0;
  bit          m_pulse = 1'b0;
  logic [1:0]  m_index = 2'b00;
  logic [31:0] m_rdata = 32'h0;
  bit          hs_aw, hs_w, hs_ar;

  function automatic bit exp_awready();
    return m_rst_done && aw_q.size() == 0 && !m_bvalid;
  endfunction
  function automatic bit exp_wready();
    return m_rst_done && w_q.size() == 0 && !m_bvalid;
  endfunction
  function automatic bit exp_arready();
    return m_rst_done && !m_rvalid;
  endfunction

  function automatic logic [31:0] apply_strb(logic [31:0] old_v, logic [31:0] d, logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old_v & ~mask) | (d & mask);
  endfunction

  initial begin
    for (int i = 0; i < 4; i++) m_regs[i] = 32'h0;
  end

  // Model advances on every rising edge from the inputs and its own state.
  always @(posedge clk) begin
    hs_aw = bus.awvalid && exp_awready();
    hs_w  = bus.wvalid && exp_wready();
    hs_ar = bus.arvalid && exp_arready();
    if (!rstn) begin
      for (int i = 0; i < 4; i++) m_regs[i] = 32'h0;
      aw_q.delete();
      w_q.delete();
      m_rst_done = 1'b0;
      m_bvalid = 1'b0;
      m_rvalid = 1'b0;
      m_pulse = 1'b0;
      m_index = 2'b00;
      m_rdata = 32'h0;
    end else begin
      m_pulse = 1'b0;
      if (m_rvalid && bus.rready) m_rvalid = 1'b0;
      if (hs_ar) begin
        m_rdata = m_regs[bus.araddr[3:2]];
        m_rvalid = 1'b1;
      end
      if (m_bvalid && bus.bready) m_bvalid = 1'b0;
      if (aw_q.size() > 0 && w_q.size() > 0) begin
        logic [1:0]  a;
        logic [35:0] wd;
        a  = aw_q.pop_front();
        wd = w_q.pop_front();
        m_regs[a] = apply_strb(m_regs[a], wd[31:0], wd[35:32]);
        m_pulse = 1'b1;
        m_index = a;
        m_bvalid = 1'b1;
      end
      if (hs_aw) aw_q.push_back(bus.awaddr[3:2]);
      if (hs_w)  w_q.push_back({bus.wstrb, bus.wdata});
      m_rst_done = 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Compare process: DUT outputs against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("awready", bus.awready, exp_awready());
      chk("wready",  bus.wready,  exp_wready());
      chk("arready", bus.arready, exp_arready());
      chk("bvalid",  bus.bvalid,  m_bvalid);
      chk("rvalid",  bus.rvalid,  m_rvalid);
      chk("rdata",   bus.rdata,   m_rdata);
      chk("bresp",   bus.bresp,   2'b00);
      chk("rresp",   bus.rresp,   2'b00);
      chk("wr_pulse", wr_pulse,   m_pulse);
      if (m_pulse) chk("wr_index", wr_index, m_index);
      chk("reg_out", reg_out, {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
      if (wr_pulse) begin
        pulse_cnt++;
        last_idx = wr_index;
      end
    end
  end

  // ---------------- driver ----------------
  function automatic bit sig(input int w);
    case (w)
      0: return bus.awready;
      1: return bus.wready;
      2: return bus.arready;
      3: return bus.bvalid;
      default: return bus.rvalid;
    endcase
  endfunction

  task automatic wait_sig(input string nm, input int w);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (sig(w)) break;
      n++;
      if (n >= 60) begin
        total++;
        bad++;
        $display("FAIL timeout_%s at %0t: got no response expected one within 60 cycles", nm, $time);
        break;
      end
    end
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int b_dly);
    fork
      begin
        if (aw_dly > 0) begin repeat (aw_dly) @(posedge clk); #1; end
        bus.awaddr = a; bus.awprot = 3'($urandom); bus.awvalid = 1'b1;
        wait_sig("awready", 0);
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
      end
      begin
        if (w_dly > 0) begin repeat (w_dly) @(posedge clk); #1; end
        bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
        wait_sig("wready", 1);
        @(posedge clk); #1;
        bus.wvalid = 1'b0;
      end
    join
    wait_sig("bvalid", 3);
    repeat (b_dly) @(negedge clk);
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a, input int ar_dly, input int r_dly,
                         output logic [31:0] d);
    if (ar_dly > 0) begin repeat (ar_dly) @(posedge clk); #1; end
    bus.araddr = a; bus.arprot = 3'($urandom); bus.arvalid = 1'b1;
    wait_sig("arready", 2);
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    wait_sig("rvalid", 4);
    repeat (r_dly) @(negedge clk);
    d = bus.rdata;
    bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.rready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no end of test expected one before 300000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] wv [4];
    int p0;
    wv[0] = 32'h0101FFFF; wv[1] = 32'hABCD0001; wv[2] = 32'hDEAD0011; wv[3] = 32'hBEEF0011;
    bus.awaddr = 4'h0; bus.awprot = 3'b000; bus.awvalid = 1'b0;
    bus.wdata = 32'h0; bus.wstrb = 4'h0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = 4'h0; bus.arprot = 3'b000; bus.arvalid = 1'b0; bus.rready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk); #1;
    chk_en = 1'b1;
    chk("rst_reg_out", reg_out, 128'h0);
    chk("rst_bvalid", bus.bvalid, 1'b0);
    chk("rst_awready", bus.awready, 1'b0);
    rstn = 1'b1;
    chk("release_awready", bus.awready, 1'b0);
    @(posedge clk); #1;

    // 1: full-word writes and read-back
    for (int i = 0; i < 4; i++) do_write(4'(i * 4), wv[i], 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      do_read(4'(i * 4), 0, 0, rd);
      chk("t1_readback", rd, wv[i]);
    end

    // 2: W leads AW by three cycles
    p0 = pulse_cnt;
    do_write(4'h4, 32'h13572468, 4'hF, 3, 0, 0);
    chk("t2_pulse_count", pulse_cnt - p0, 1);
    chk("t2_index", last_idx, 2'd1);

    // 3: partial strobe on reg2
    do_write(4'h8, 32'h12345678, 4'b0101, 0, 0, 0);
    do_read(4'hA, 0, 0, rd);
    chk("t3_strobe", rd, 32'hDE340078);

    // 4: B held off for 5 cycles (READYs checked against the model each cycle)
    do_write(4'h0, 32'h0F0F0F0F, 4'hF, 0, 0, 5);

    // 5: R held off for 4 cycles on reg3
    do_read(4'hC, 0, 4, rd);
    chk("t5_rdata", rd, 32'hBEEF0011);

    // Read on the commit edge returns the pre-write value
    fork
      do_write(4'h4, 32'hCAFEBABE, 4'hF, 0, 0, 0);
      do_read(4'h4, 1, 0, rd);
    join
    chk("collide_old", rd, 32'h13572468);
    do_read(4'h5, 0, 0, rd);
    chk("collide_new", rd, 32'hCAFEBABE);

    // 6: reset with AW held and W missing
    bus.awaddr = 4'h0; bus.awvalid = 1'b1;
    wait_sig("awready", 0);
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    p0 = pulse_cnt;
    rstn = 1'b0;
    repeat (2) @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      do_read(4'(i * 4), 0, 0, rd);
      chk("t6_cleared", rd, 32'h0);
    end
    chk("t6_no_pulse", pulse_cnt - p0, 0);
    do_write(4'h8, 32'h55AA55AA, 4'hF, 0, 0, 0);
    do_read(4'h8, 0, 0, rd);
    chk("t6_after", rd, 32'h55AA55AA);

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      int op;
      op = int'($urandom_range(0, 2));
      if (op == 0) begin
        do_write(4'($urandom), $urandom, 4'($urandom),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end else if (op == 1) begin
        do_read(4'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rd);
      end else begin
        fork
          do_write(4'($urandom), $urandom, 4'($urandom),
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
          do_read(4'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), rd);
        join
      end
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
